// File: rtl/mine_placer.sv
// rtl/mine_placer.sv - clears the board, then places mines at LFSR-chosen cells and strobes neighbour increments
// Outputs are Moore-decoded from the registered state; the board samples them on the next edge.
module mine_placer #(
  parameter int                   WIDTH     = 8,
  parameter int                   HEIGHT    = 8,
  parameter int                   BUS_WIDTH = 8,
  parameter logic [BUS_WIDTH-1:0] MINE_VAL  = 8'hF0,
  parameter logic [15:0]          LFSR_INIT = 16'hACE1,
  localparam int XW    = $clog2(WIDTH),
  localparam int YW    = $clog2(HEIGHT),
  localparam int CELLS = WIDTH * HEIGHT,
  localparam int CW    = $clog2(CELLS + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_start,
  input  logic [CW-1:0]        i_numMines,
  input  logic [15:0]          i_seed,
  input  logic [XW-1:0]        i_safeX,
  input  logic [YW-1:0]        i_safeY,
  output logic [XW-1:0]        o_readX,
  output logic [YW-1:0]        o_readY,
  input  logic [BUS_WIDTH-1:0] i_readValue,
  output logic                 o_writeEn,
  output logic                 o_incAdjacent,
  output logic [XW-1:0]        o_writeX,
  output logic [YW-1:0]        o_writeY,
  output logic [BUS_WIDTH-1:0] o_writeValue,
  output logic                 o_busy,
  output logic                 o_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_GEN, S_CHECK, S_PLACE, S_INC, S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_target;
  logic [CW-1:0] r_placed;
  logic [15:0]   r_lfsr;
  logic [XW-1:0] r_safe_x;
  logic [YW-1:0] r_safe_y;
  logic [XW-1:0] r_clr_x;
  logic [YW-1:0] r_clr_y;

  logic [CW-1:0] w_clamped;
  logic [15:0]   w_lfsr_next;
  logic [XW-1:0] w_cand_x;
  logic [YW-1:0] w_cand_y;
  logic          w_last_cell;
  logic          w_reject;
  logic [CW-1:0] w_placed_inc;

  // The safe cell can never hold a mine, so at most CELLS-1 can be placed.
  assign w_clamped = (i_numMines > CW'(CELLS - 1)) ? CW'(CELLS - 1) : i_numMines;

  assign w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);

  // The LFSR only moves in GEN, so the candidate is stable through CHECK/PLACE/INC.
  assign w_cand_x = r_lfsr[XW-1:0];
  assign w_cand_y = r_lfsr[XW+YW-1:XW];

  assign w_last_cell  = (r_clr_x == XW'(WIDTH - 1)) && (r_clr_y == YW'(HEIGHT - 1));
  assign w_placed_inc = r_placed + CW'(1);

  assign w_reject = ({1'b0, w_cand_x} >= (XW+1)'(WIDTH))
                 || ({1'b0, w_cand_y} >= (YW+1)'(HEIGHT))
                 || ((w_cand_x == r_safe_x) && (w_cand_y == r_safe_y))
                 || (i_readValue >= MINE_VAL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_target <= '0;
      r_placed <= '0;
      r_lfsr   <= LFSR_INIT;
      r_safe_x <= '0;
      r_safe_y <= '0;
      r_clr_x  <= '0;
      r_clr_y  <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_target <= w_clamped;
            r_lfsr   <= (i_seed == 16'h0000) ? LFSR_INIT : i_seed;
            r_safe_x <= i_safeX;
            r_safe_y <= i_safeY;
            r_placed <= '0;
            r_clr_x  <= '0;
            r_clr_y  <= '0;
          end
        end
        S_CLEAR: begin
          if (r_clr_x == XW'(WIDTH - 1)) begin
            r_clr_x <= '0;
            r_clr_y <= w_last_cell ? '0 : r_clr_y + YW'(1);
          end else begin
            r_clr_x <= r_clr_x + XW'(1);
          end
        end
        S_GEN: r_lfsr <= w_lfsr_next;
        S_INC: r_placed <= w_placed_inc;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next        = r_state;
    o_readX       = '0;
    o_readY       = '0;
    o_writeEn     = 1'b0;
    o_incAdjacent = 1'b0;
    o_writeX      = '0;
    o_writeY      = '0;
    o_writeValue  = '0;
    o_busy        = 1'b1;
    o_done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_busy = 1'b0;
        if (i_start) w_next = S_CLEAR;
      end
      S_CLEAR: begin
        o_writeEn = 1'b1;
        o_writeX  = r_clr_x;
        o_writeY  = r_clr_y;
        if (w_last_cell) w_next = (r_target == '0) ? S_DONE : S_GEN;
      end
      S_GEN: w_next = S_CHECK;
      S_CHECK: begin
        o_readX = w_cand_x;
        o_readY = w_cand_y;
        w_next  = w_reject ? S_GEN : S_PLACE;
      end
      S_PLACE: begin
        o_writeEn    = 1'b1;
        o_writeValue = MINE_VAL;
        o_writeX     = w_cand_x;
        o_writeY     = w_cand_y;
        w_next       = S_INC;
      end
      S_INC: begin
        o_incAdjacent = 1'b1;
        o_writeX      = w_cand_x;
        o_writeY      = w_cand_y;
        w_next        = (w_placed_inc == r_target) ? S_DONE : S_GEN;
      end
      S_DONE: begin
        o_done = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        o_busy = 1'b0;
        w_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mine_placer.sv
// tb/tb_mine_placer.sv - directed bench for mine_placer with a board model and a per-cycle output timeline model
module tb_mine_placer;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       we;
    logic       inc;
    logic [2:0] wx;
    logic [2:0] wy;
    logic [7:0] wv;
    logic [2:0] rx;
    logic [2:0] ry;
  } outs_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic [6:0]  nm_a = '0;
  logic [4:0]  nm_b = '0;
  logic [15:0] seed = '0;
  logic [2:0]  sx = '0, sy = '0;
  logic        sel = 1'b0;
  logic        pre_a = 1'b0, pre_b = 1'b0;

  logic [2:0] rx_a, ry_a, wx_a, wy_a, rx_b, ry_b, wx_b, wy_b;
  logic [7:0] rv_a, rv_b, wv_a, wv_b;
  logic       we_a, inc_a, busy_a, done_a, we_b, inc_b, busy_b, done_b;
  outs_t      outs_a, outs_b;

  logic [7:0] mem_a [64];
  logic [7:0] mem_b [30];
  int         inc_cnt_a = 0, inc_cnt_b = 0;

  outs_t exp_q [$];
  bit    exp_mine [64];
  int    first_place, first_inc, done_idx, model_mines;
  int    n_vec = 0, n_fail = 0;

  always #5 clk = ~clk;

  mine_placer u_a (
    .clk(clk), .reset(reset), .i_start(start_a), .i_numMines(nm_a), .i_seed(seed),
    .i_safeX(sx), .i_safeY(sy), .o_readX(rx_a), .o_readY(ry_a), .i_readValue(rv_a),
    .o_writeEn(we_a), .o_incAdjacent(inc_a), .o_writeX(wx_a), .o_writeY(wy_a),
    .o_writeValue(wv_a), .o_busy(busy_a), .o_done(done_a)
  );

  mine_placer #(.WIDTH(6), .HEIGHT(5)) u_b (
    .clk(clk), .reset(reset), .i_start(start_b), .i_numMines(nm_b), .i_seed(seed),
    .i_safeX(sx), .i_safeY(sy), .o_readX(rx_b), .o_readY(ry_b), .i_readValue(rv_b),
    .o_writeEn(we_b), .o_incAdjacent(inc_b), .o_writeX(wx_b), .o_writeY(wy_b),
    .o_writeValue(wv_b), .o_busy(busy_b), .o_done(done_b)
  );

  assign outs_a = {busy_a, done_a, we_a, inc_a, wx_a, wy_a, wv_a, rx_a, ry_a};
  assign outs_b = {busy_b, done_b, we_b, inc_b, wx_b, wy_b, wv_b, rx_b, ry_b};
  assign rv_a   = mem_a[int'(ry_a) * 8 + int'(rx_a)];
  assign rv_b   = (ry_b < 3'd5 && rx_b < 3'd6) ? mem_b[int'(ry_b) * 6 + int'(rx_b)] : 8'h00;

  // Board model: write port plus increment of the (in-range) eight neighbours.
  always @(posedge clk) begin
    if (pre_a) begin
      for (int i = 0; i < 64; i++) mem_a[i] <= 8'h55;
      inc_cnt_a <= 0;
    end else begin
      if (we_a) mem_a[int'(wy_a) * 8 + int'(wx_a)] <= wv_a;
      if (inc_a) begin
        inc_cnt_a <= inc_cnt_a + 1;
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++)
            if (!(dx == 0 && dy == 0) && int'(wx_a) + dx >= 0 && int'(wx_a) + dx < 8 &&
                int'(wy_a) + dy >= 0 && int'(wy_a) + dy < 8)
              mem_a[(int'(wy_a) + dy) * 8 + int'(wx_a) + dx] <=
                mem_a[(int'(wy_a) + dy) * 8 + int'(wx_a) + dx] + 8'd1;
      end
    end
  end

  always @(posedge clk) begin
    if (pre_b) begin
      for (int i = 0; i < 30; i++) mem_b[i] <= 8'h55;
      inc_cnt_b <= 0;
    end else begin
      if (we_b && wx_b < 3'd6 && wy_b < 3'd5) mem_b[int'(wy_b) * 6 + int'(wx_b)] <= wv_b;
      if (inc_b) begin
        inc_cnt_b <= inc_cnt_b + 1;
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++)
            if (!(dx == 0 && dy == 0) && int'(wx_b) + dx >= 0 && int'(wx_b) + dx < 6 &&
                int'(wy_b) + dy >= 0 && int'(wy_b) + dy < 5)
              mem_b[(int'(wy_b) + dy) * 6 + int'(wx_b) + dx] <=
                mem_b[(int'(wy_b) + dy) * 6 + int'(wx_b) + dx] + 8'd1;
      end
    end
  end

  task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic chk_ge(input string name, input logic [31:0] act, input logic [31:0] lim);
    n_vec++;
    if (!(act >= lim)) begin
      n_fail++;
      $display("FAIL %s: got %h, expected >= %h", name, act, lim);
    end
  endtask

  function automatic outs_t mk(bit b, bit d, bit w, bit i, int x, int y, int v, int rx, int ry);
    outs_t o;
    o.busy = b; o.done = d; o.we = w; o.inc = i;
    o.wx = 3'(x); o.wy = 3'(y); o.wv = 8'(v); o.rx = 3'(rx); o.ry = 3'(ry);
    return o;
  endfunction

  // One clock: compare outputs at the falling edge, return just after the rising edge.
  task automatic tick();
    outs_t e;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk_eq("cycle_outputs", sel ? outs_b : outs_a, e);
    end
    @(posedge clk);
    #1;
  endtask

  // Expected cycle-by-cycle timeline of one setup, derived from the game rules.
  task automatic build(input bit s, input int nm, input logic [15:0] sd, input int sxx, input int syy);
    int w, h, n, tgt, placed, x, y, guard;
    logic [15:0] l;
    w = s ? 6 : 8; h = s ? 5 : 8; n = w * h;
    tgt = (nm > n - 1) ? n - 1 : nm;
    for (int i = 0; i < 64; i++) exp_mine[i] = 1'b0;
    exp_q.delete();
    first_place = 0; first_inc = 0;
    for (int i = 0; i < n; i++) exp_q.push_back(mk(1, 0, 1, 0, i % w, i / w, 0, 0, 0));
    l = (sd == 16'h0) ? 16'hACE1 : sd;
    placed = 0; guard = 0;
    while (placed < tgt && guard < 20000) begin
      l = (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
      x = int'(l[2:0]); y = int'(l[5:3]);
      exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
      exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, x, y));
      if (x < w && y < h && !(x == sxx && y == syy) && !exp_mine[y * w + x]) begin
        exp_mine[y * w + x] = 1'b1;
        exp_q.push_back(mk(1, 0, 1, 0, x, y, 8'hF0, 0, 0));
        if (first_place == 0) first_place = exp_q.size();
        exp_q.push_back(mk(1, 0, 0, 1, x, y, 0, 0, 0));
        if (first_inc == 0) first_inc = exp_q.size();
        placed++;
      end
      guard++;
    end
    exp_q.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0));
    done_idx = exp_q.size();
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    model_mines = placed;
  endtask

  task automatic drain();
    int budget = 0;
    while (exp_q.size() > 0) begin
      tick();
      budget++;
      if (budget > 30000) begin
        chk_eq("drain_timeout", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
      end
    end
  endtask

  task automatic preload(input bit s);
    if (s) pre_b = 1'b1; else pre_a = 1'b1;
    tick();
    pre_a = 1'b0; pre_b = 1'b0;
  endtask

  // mode 0: plain run; 1: stray start during first PLACE; 2: reset during first INC
  task automatic run(input bit s, input int nm, input logic [15:0] sd, input int sxx, input int syy,
                     input int mode);
    sel = s; seed = sd; sx = 3'(sxx); sy = 3'(syy);
    if (s) begin nm_b = 5'(nm); start_b = 1'b1; end
    else begin nm_a = 7'(nm); start_a = 1'b1; end
    tick();
    start_a = 1'b0; start_b = 1'b0;
    build(s, nm, sd, sxx, syy);
    if (mode == 1) begin
      repeat (first_place - 1) tick();
      nm_a = 7'd3; seed = 16'h7777; start_a = 1'b1;
      tick();
      start_a = 1'b0;
    end else if (mode == 2) begin
      repeat (first_inc - 1) tick();
      exp_q.delete();
      exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
      exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
      reset = 1'b1;
      tick();
      reset = 1'b0;
    end
    drain();
  endtask

  task automatic check_board(input bit s, output int dut_mines);
    int w, h, nb;
    logic [7:0] v;
    w = s ? 6 : 8; h = s ? 5 : 8;
    dut_mines = 0;
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++) begin
        v = s ? mem_b[y * w + x] : mem_a[y * w + x];
        if (v >= 8'hF0) dut_mines++;
        if (exp_mine[y * w + x]) chk_ge("mine_cell", 32'(v), 32'hF0);
        else begin
          nb = 0;
          for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++)
              if (!(dx == 0 && dy == 0) && x + dx >= 0 && x + dx < w && y + dy >= 0 && y + dy < h)
                nb += int'(exp_mine[(y + dy) * w + x + dx]);
          chk_eq("count_cell", 32'(v), 32'(nb));
        end
      end
  endtask

  initial begin
    int m;
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    tick();
    reset = 1'b0;
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    tick();

    preload(0);
    run(0, 0, 16'h0001, 0, 0, 0);
    chk_eq("t1_done_cycle", 32'(done_idx), 32'd65);
    check_board(0, m);
    chk_eq("t1_mines", 32'(m), 32'd0);

    preload(0);
    run(0, 10, 16'h1234, 3, 4, 0);
    check_board(0, m);
    chk_eq("t2_model_mines", 32'(model_mines), 32'd10);
    chk_eq("t2_mines", 32'(m), 32'd10);
    chk_eq("t2_safe_not_mine", 32'(mem_a[4 * 8 + 3] < 8'hF0), 32'd1);
    chk_eq("t2_inc_pulses", 32'(inc_cnt_a), 32'd10);

    preload(0);
    run(0, 64, 16'hBEEF, 0, 0, 0);
    check_board(0, m);
    chk_eq("t3_mines", 32'(m), 32'd63);
    chk_eq("t3_safe_count", 32'(mem_a[0]), 32'd3);

    preload(0);
    run(0, 20, 16'h0F0F, 2, 2, 1);
    check_board(0, m);
    chk_eq("t4_mines", 32'(m), 32'd20);

    preload(0);
    run(0, 12, 16'h00A5, 1, 1, 2);
    run(0, 5, 16'h0000, 7, 7, 0);
    check_board(0, m);
    chk_eq("t5_mines", 32'(m), 32'd5);

    preload(1);
    run(1, 29, 16'h5A5A, 5, 4, 0);
    check_board(1, m);
    chk_eq("t6_mines", 32'(m), 32'd29);
    chk_eq("t6_inc_pulses", 32'(inc_cnt_b), 32'd29);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
